// File: rtl/alu_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// alu_pkt_ctrl
//   Packet controller between a UART byte interface and a 32-bit integer ALU.
//   Parses framed command packets (opcode, reserved, LEN lo, LEN hi, payload)
//   from the receive byte stream. For add/sub/xor it folds the little-endian
//   32-bit payload words into an accumulator and returns the 4-byte result
//   LSB first. For echo it queues the payload in a small FIFO that drains to
//   the transmit port on its own.
//
//   Optional feature macro: ALU_CTRL_TIMEOUT_EN
//     defined   -> inter-byte timeout of TIMEOUT_CYCLES in header/payload/
//                  discard states (err_o pulse, back to IDLE, acc cleared)
//     undefined -> controller waits indefinitely between bytes
//
// Parameters
//   FIFO_DEPTH      echo buffer depth in bytes (power of two, >= 2)
//   TIMEOUT_CYCLES  inter-byte timeout (only with ALU_CTRL_TIMEOUT_EN)
//
// Ports
//   clk_i       in   clock
//   rst_ni      in   asynchronous active-low reset
//   rx_data_i   in   received byte
//   rx_valid_i  in   one-cycle strobe qualifying rx_data_i (no backpressure)
//   tx_data_o   out  byte to transmit
//   tx_valid_o  out  tx_data_o valid, held until accepted
//   tx_ready_i  in   transmitter accepts on tx_valid_o && tx_ready_i
//   busy_o      out  high whenever the controller is not in IDLE
//   err_o       out  one-cycle pulse on any protocol error
// ---------------------------------------------------------------------------
module alu_pkt_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_SUB  = 8'hA1;
    localparam logic [7:0] OP_XOR  = 8'hA2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSVD,
        S_LEN_L,
        S_LEN_H,
        S_PAYLOAD,
        S_RESULT,
        S_DISCARD
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  opcode_reg, opcode_next;
    logic [7:0]  len_lo_reg, len_lo_next;
    logic [15:0] remain_reg, remain_next;
    logic [31:0] word_reg, word_next;
    logic [1:0]  byte_idx_reg, byte_idx_next;
    logic        first_reg, first_next;
    logic [31:0] acc_reg, acc_next;
    logic [1:0]  res_idx_reg, res_idx_next;
    logic        err_reg, err_next;

    // Echo FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic        fifo_empty, fifo_full;
    logic        fifo_push, fifo_pop, push_ok;

    logic        timeout_fire;

    // Header / ALU helpers
    logic [15:0] len_full;
    logic [15:0] payload_len;
    logic        opcode_ok;
    logic        is_echo;
    logic [31:0] word_cur;
    logic [31:0] alu_out;
    logic        word_done;
    logic        result_pop;
    logic [7:0]  acc_bytes [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_acc_bytes
            assign acc_bytes[gi] = acc_reg[8*gi +: 8];
        end
    endgenerate

    assign len_full    = {rx_data_i, len_lo_reg};
    assign payload_len = (len_full < 16'd4) ? 16'd0 : (len_full - 16'd4);
    assign opcode_ok   = (opcode_reg == OP_ECHO) || (opcode_reg == OP_ADD) ||
                         (opcode_reg == OP_SUB)  || (opcode_reg == OP_XOR);
    assign is_echo     = (opcode_reg == OP_ECHO);

    // Bytes land LSB-first; a short final word keeps zeros in its upper lanes
    // because word_reg is cleared every time a word is applied.
    assign word_cur  = word_reg | ({24'd0, rx_data_i} << {byte_idx_reg, 3'b000});
    assign word_done = (byte_idx_reg == 2'd3) || (remain_reg == 16'd1);

    always_comb begin
        case (opcode_reg)
            OP_SUB:  alu_out = acc_reg - word_cur;
            OP_XOR:  alu_out = acc_reg ^ word_cur;
            default: alu_out = acc_reg + word_cur;
        endcase
    end

    // ---------------- FIFO status ----------------
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign fifo_pop   = !fifo_empty && tx_ready_i;
    // A pop in the same cycle frees a slot, so a push into a full FIFO works.
    assign push_ok    = fifo_push && (!fifo_full || fifo_pop);

    // Result bytes queue behind any echo bytes still in the FIFO.
    assign result_pop = (state_reg == S_RESULT) && fifo_empty && tx_ready_i;

    always_comb begin
        tx_data_o  = 8'h00;
        tx_valid_o = 1'b0;
        if (!fifo_empty) begin
            tx_data_o  = fifo_mem[rd_ptr_reg[AW-1:0]];
            tx_valid_o = 1'b1;
        end else if (state_reg == S_RESULT) begin
            tx_data_o  = acc_bytes[res_idx_reg];
            tx_valid_o = 1'b1;
        end
    end

    assign busy_o = (state_reg != S_IDLE);
    assign err_o  = err_reg;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next    = state_reg;
        opcode_next   = opcode_reg;
        len_lo_next   = len_lo_reg;
        remain_next   = remain_reg;
        word_next     = word_reg;
        byte_idx_next = byte_idx_reg;
        first_next    = first_reg;
        acc_next      = acc_reg;
        res_idx_next  = res_idx_reg;
        err_next      = 1'b0;
        fifo_push     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (rx_valid_i) begin
                    opcode_next = rx_data_i;
                    state_next  = S_RSVD;
                end
            end
            S_RSVD: begin
                if (rx_valid_i) state_next = S_LEN_L;
            end
            S_LEN_L: begin
                if (rx_valid_i) begin
                    len_lo_next = rx_data_i;
                    state_next  = S_LEN_H;
                end
            end
            S_LEN_H: begin
                if (rx_valid_i) begin
                    remain_next   = payload_len;
                    word_next     = 32'd0;
                    byte_idx_next = 2'd0;
                    first_next    = 1'b1;
                    acc_next      = 32'd0;
                    res_idx_next  = 2'd0;
                    if (!opcode_ok) begin
                        err_next   = 1'b1;
                        state_next = (payload_len == 16'd0) ? S_IDLE : S_DISCARD;
                    end else if (payload_len == 16'd0) begin
                        // An empty echo has nothing to send; an empty ALU
                        // packet returns the cleared accumulator.
                        state_next = is_echo ? S_IDLE : S_RESULT;
                    end else begin
                        state_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid_i) begin
                    remain_next = remain_reg - 16'd1;
                    if (is_echo) begin
                        fifo_push = 1'b1;
                        if (!push_ok) err_next = 1'b1;
                        if (remain_reg == 16'd1) state_next = S_IDLE;
                    end else begin
                        if (word_done) begin
                            acc_next      = first_reg ? word_cur : alu_out;
                            word_next     = 32'd0;
                            byte_idx_next = 2'd0;
                            first_next    = 1'b0;
                        end else begin
                            word_next     = word_cur;
                            byte_idx_next = byte_idx_reg + 2'd1;
                        end
                        if (remain_reg == 16'd1) begin
                            state_next   = S_RESULT;
                            res_idx_next = 2'd0;
                        end
                    end
                end
            end
            S_RESULT: begin
                if (rx_valid_i) err_next = 1'b1;
                if (result_pop) begin
                    res_idx_next = res_idx_reg + 2'd1;
                    if (res_idx_reg == 2'd3) begin
                        state_next = S_IDLE;
                        acc_next   = 32'd0;
                    end
                end
            end
            S_DISCARD: begin
                if (rx_valid_i) begin
                    remain_next = remain_reg - 16'd1;
                    if (remain_reg == 16'd1) state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Timeout only fires without an rx byte in a timed state, so it
        // never collides with a push or an accumulator update.
        if (timeout_fire) begin
            state_next = S_IDLE;
            err_next   = 1'b1;
            acc_next   = 32'd0;
        end
    end

    // ---------------- optional inter-byte timeout ----------------
`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          timed;

    assign timed = (state_reg == S_RSVD) || (state_reg == S_LEN_L) ||
                   (state_reg == S_LEN_H) || (state_reg == S_PAYLOAD) ||
                   (state_reg == S_DISCARD);
    assign timeout_fire = timed && !rx_valid_i &&
                          (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_cnt_next = to_cnt_reg + {{(TW-1){1'b0}}, 1'b1};
        if (rx_valid_i || !timed || timeout_fire) to_cnt_next = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) to_cnt_reg <= '0;
        else         to_cnt_reg <= to_cnt_next;
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= S_IDLE;
            opcode_reg   <= 8'h00;
            len_lo_reg   <= 8'h00;
            remain_reg   <= 16'd0;
            word_reg     <= 32'd0;
            byte_idx_reg <= 2'd0;
            first_reg    <= 1'b1;
            acc_reg      <= 32'd0;
            res_idx_reg  <= 2'd0;
            err_reg      <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            opcode_reg   <= opcode_next;
            len_lo_reg   <= len_lo_next;
            remain_reg   <= remain_next;
            word_reg     <= word_next;
            byte_idx_reg <= byte_idx_next;
            first_reg    <= first_next;
            acc_reg      <= acc_next;
            res_idx_reg  <= res_idx_next;
            err_reg      <= err_next;
            if (push_ok)  wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_mem[wr_ptr_reg[AW-1:0]] <= rx_data_i;
    end

endmodule

// File: tb/tb_alu_pkt_ctrl.sv
module tb_alu_pkt_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       err_o;

    alu_pkt_ctrl #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int tx_seen = 0;

    always @(posedge clk_i) begin
        if (err_o)      err_cnt++;
        if (tx_valid_o) tx_seen++;
    end

    typedef struct {
        logic [7:0]  op;
        logic [15:0] len;
        int          n;
        logic [63:0] pl;
        logic [31:0] res;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
        send_byte(op);
        send_byte(8'h00);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    // Waits (bounded) for a tx byte, compares it, then lets one edge accept it
    // (tx_ready_i is assumed high by the caller).
    task automatic expect_tx(input logic [7:0] exp, input string name);
        int w = 0;
        while (!tx_valid_o && w < 50) begin
            tick(1);
            w++;
        end
        check(tx_valid_o == 1'b1, {name, " valid"}, int'(tx_valid_o), 1);
        check(tx_data_o == exp, {name, " data"}, int'(tx_data_o), int'(exp));
        tick(1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int e0 = err_cnt;
        tx_ready_i = 1'b1;
        send_hdr(v.op, v.len);
        for (int i = 0; i < v.n; i++) send_byte(v.pl[8*i +: 8]);
        check(tx_valid_o == 1'b1, {name, " latency"}, int'(tx_valid_o), 1);
        for (int k = 0; k < 4; k++)
            expect_tx(v.res[8*k +: 8], $sformatf("%s res%0d", name, k));
        check(busy_o == 1'b0, {name, " idle"}, int'(busy_o), 0);
        check(tx_valid_o == 1'b0, {name, " tx done"}, int'(tx_valid_o), 0);
        check(err_cnt == e0, {name, " no err"}, err_cnt - e0, 0);
    endtask

    initial begin
        int e0;
        int t0;

        vecs[0] = '{8'hA0, 16'd12, 8, 64'h00000002_00000001, 32'h00000003};
        vecs[1] = '{8'hA1, 16'd12, 8, 64'h00000001_00000000, 32'hFFFFFFFF};
        vecs[2] = '{8'hA2, 16'd6,  2, 64'h0000000000000FFF, 32'h00000FFF};
        vecs[3] = '{8'hA0, 16'd4,  0, 64'h0,                32'h00000000};
        vecs[4] = '{8'hA0, 16'd2,  0, 64'h0,                32'h00000000};
        vecs[5] = '{8'hA1, 16'd12, 8, 64'h00000003_00000010, 32'h0000000D};
        vecs[6] = '{8'hA0, 16'd12, 8, 64'h00000002_FFFFFFFF, 32'h00000001};
        vecs[7] = '{8'hA2, 16'd10, 6, 64'h000080F0_0000000F, 32'h000080FF};
        vecs[8] = '{8'hA0, 16'd5,  1, 64'h000000000000007F, 32'h0000007F};

        rst_ni     = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b0;
        tick(3);
        check(tx_valid_o == 1'b0, "reset tx_valid", int'(tx_valid_o), 0);
        check(tx_data_o == 8'h00, "reset tx_data", int'(tx_data_o), 0);
        check(busy_o == 1'b0, "reset busy", int'(busy_o), 0);
        check(err_o == 1'b0, "reset err", int'(err_o), 0);
        rst_ni = 1'b1;
        tick(2);

        // Table-driven ALU packets
        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Echo with backpressure and an overflowing 5th byte
        tx_ready_i = 1'b0;
        e0 = err_cnt;
        send_hdr(8'hEC, 16'd9);
        send_byte(8'h11);
        check(tx_valid_o == 1'b1 && tx_data_o == 8'h11, "echo first latency",
              int'(tx_data_o), 8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        check(busy_o == 1'b0, "echo back to idle", int'(busy_o), 0);
        tick(2);
        check(err_cnt == e0 + 1, "echo overflow err", err_cnt - e0, 1);
        tick(20);
        check(tx_valid_o == 1'b1 && tx_data_o == 8'h11, "echo held",
              int'(tx_data_o), 8'h11);
        tx_ready_i = 1'b1;
        expect_tx(8'h11, "echo b0");
        expect_tx(8'h22, "echo b1");
        expect_tx(8'h33, "echo b2");
        expect_tx(8'h44, "echo b3");
        check(tx_valid_o == 1'b0, "echo drained (55 dropped)", int'(tx_valid_o), 0);

        // Result queues behind echo bytes still in the FIFO
        tx_ready_i = 1'b0;
        send_hdr(8'hEC, 16'd6);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_hdr(8'hA0, 16'd4);
        check(busy_o == 1'b1, "queued result busy", int'(busy_o), 1);
        check(tx_data_o == 8'hAA, "echo ahead of result", int'(tx_data_o), 8'hAA);
        tx_ready_i = 1'b1;
        expect_tx(8'hAA, "order b0");
        expect_tx(8'hBB, "order b1");
        for (int k = 0; k < 4; k++) expect_tx(8'h00, $sformatf("order r%0d", k));
        check(busy_o == 1'b0, "order idle", int'(busy_o), 0);

        // Invalid opcode: discarded, one error, nothing sent, then a clean packet
        e0 = err_cnt;
        t0 = tx_seen;
        send_hdr(8'h55, 16'd6);
        send_byte(8'hAA);
        send_byte(8'hBB);
        tick(1);
        check(err_cnt == e0 + 1, "invalid err", err_cnt - e0, 1);
        check(tx_seen == t0, "invalid no tx", tx_seen - t0, 0);
        check(busy_o == 1'b0, "invalid idle", int'(busy_o), 0);
        run_vec(vecs[3], "after invalid");

        // rx byte during RESULT is dropped with an error
        tx_ready_i = 1'b0;
        send_hdr(8'hA0, 16'd8);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        e0 = err_cnt;
        send_byte(8'h99);
        tick(1);
        check(err_cnt == e0 + 1, "result rx err", err_cnt - e0, 1);
        check(busy_o == 1'b1, "result still busy", int'(busy_o), 1);
        tx_ready_i = 1'b1;
        expect_tx(8'h01, "rdrop r0");
        expect_tx(8'h02, "rdrop r1");
        expect_tx(8'h00, "rdrop r2");
        expect_tx(8'h00, "rdrop r3");

        // Reset mid-packet
        send_hdr(8'hA0, 16'd12);
        send_byte(8'h01);
        send_byte(8'h00);
        rst_ni = 1'b0;
        #1;
        check(busy_o == 1'b0, "midreset busy", int'(busy_o), 0);
        check(tx_valid_o == 1'b0, "midreset tx_valid", int'(tx_valid_o), 0);
        check(tx_data_o == 8'h00, "midreset tx_data", int'(tx_data_o), 0);
        check(err_o == 1'b0, "midreset err", int'(err_o), 0);
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        run_vec(vecs[0], "post reset add");

        // Inter-byte timeout
        e0 = err_cnt;
        send_byte(8'hA0);
        send_byte(8'h00);
        tick(110);
`ifdef ALU_CTRL_TIMEOUT_EN
        check(err_cnt == e0 + 1, "timeout err", err_cnt - e0, 1);
        check(busy_o == 1'b0, "timeout idle", int'(busy_o), 0);
`else
        check(err_cnt == e0, "no timeout err", err_cnt - e0, 0);
        check(busy_o == 1'b1, "no timeout busy", int'(busy_o), 1);
`endif
        rst_ni = 1'b0;
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        run_vec(vecs[1], "final sub");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_pkt_ctrl.md
# alu_pkt_ctrl

Packet controller between the UART byte interface and a 32-bit integer ALU. Parses framed command packets from the receive byte stream, sequences the arithmetic over little-endian 32-bit operands, and returns the result, or echoes the payload, through a valid/ready transmit byte port. It sits between `uart_mod` rx/tx and the top-level pins, in the 100 MHz PLL domain.

## Interface
- `FIFO_DEPTH`, 4: echo buffer depth in bytes; power of two, ≥2.
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte timeout. Used only with `ALU_CTRL_TIMEOUT_EN`.
- `clk_i` in 1: single clock, 100 MHz domain.
- `rst_ni` in 1: asynchronous, active-low reset.
- `rx_data_i` in 8: received byte.
- `rx_valid_i` in 1: one-cycle strobe; `rx_data_i` is valid in that cycle. No backpressure.
- `tx_data_o` out 8: byte to transmit.
- `tx_valid_o` out 1: `tx_data_o` is valid; held until accepted.
- `tx_ready_i` in 1: transmitter accepts the byte when `tx_valid_o && tx_ready_i`.
- `busy_o` out 1: high in any state other than IDLE.
- `err_o` out 1: one-cycle pulse on any protocol error.

## Operation
- Packet layout: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8].
  - LEN is the total packet length including the 4-byte header.
  - The payload is LEN−4 bytes. If LEN<4, the payload is treated as 0 bytes.
- Opcodes:
  - 0xEC echo.
  - 0xA0 add.
  - 0xA1 sub.
  - 0xA2 xor.
  - Any other value is invalid.
- States:
  - IDLE → RSVD → LEN_L → LEN_H. Each transition happens on `rx_valid_i`.
  - LEN_H → PAYLOAD, or → RESULT when the payload is 0 bytes.
  - PAYLOAD → RESULT for add/sub/xor; → IDLE for echo. The transition happens on the last payload byte.
  - RESULT → IDLE after the 4th result byte is accepted.
  - Invalid opcode: `err_o` pulses at LEN_H. The controller enters DISCARD, consumes LEN−4 bytes, then returns to IDLE.
- ALU sequencing:
  - Payload bytes are assembled LSB-first into 32-bit words.
  - The first word loads the accumulator. Each later word does acc = acc OP word.
  - All arithmetic is mod 2^32; carries and borrows are discarded.
  - A partial final word (payload length not a multiple of 4) is zero-extended in its upper bytes and then applied.
  - An empty payload gives result 0.
- Result: 4 bytes, LSB first, on the tx port.
- Echo:
  - Each payload byte is pushed into the FIFO. The FIFO drives the tx port whenever it is not empty.
  - A push while the FIFO is full drops the byte and pulses `err_o`.
  - The controller returns to IDLE at the last payload byte. The FIFO drains independently.
  - A new packet's header may arrive while the FIFO is draining.
  - A result may not enter the tx path until the FIFO is empty. Result bytes wait behind any echo bytes still queued.
- An `rx_valid_i` in RESULT state drops the byte and pulses `err_o`. The state is unchanged.

## Timing
- Reset values: `tx_valid_o`=0, `tx_data_o`=0x00, `busy_o`=0, `err_o`=0, state=IDLE, FIFO empty, accumulator=0.
- Reset asserted mid-packet or mid-transmit aborts immediately. After release, the controller waits for a fresh opcode.
- Every `rx_valid_i` is consumed in the same cycle. The state, counter and accumulator update at that clock edge.
- Result latency: `tx_valid_o` rises 1 cycle after the edge that captures the last payload byte (or LEN_H when the payload is empty), provided the FIFO is empty.
- Each accepted result byte advances to the next byte on the following cycle.
- `tx_data_o` and `tx_valid_o` are stable while `tx_valid_o && !tx_ready_i`.
- Echo: a byte pushed into an empty FIFO appears on `tx_*` 1 cycle after the push edge.
  - Push and pop in the same cycle are both honoured.
  - When full, a simultaneous pop frees a slot, so the push succeeds.
- The payload counter is 16 bits. LEN=0xFFFF gives a payload of 65531 bytes with no wrap.

## Configuration
- `ALU_CTRL_TIMEOUT_EN` defined:
  - A counter resets on every `rx_valid_i` and runs in RSVD, LEN_L, LEN_H, PAYLOAD and DISCARD.
  - When it reaches `TIMEOUT_CYCLES`, `err_o` pulses and the state returns to IDLE. The accumulator clears; the FIFO is kept.
  - RESULT and IDLE never time out.
- `ALU_CTRL_TIMEOUT_EN` undefined: no counter. The controller waits indefinitely between bytes.

## Test plan
- Add: EC-free packet A0 00 0C 00, 01 00 00 00, 02 00 00 00 → tx 03 00 00 00, with `tx_valid_o` rising 1 cycle after the last rx byte.
- Sub wrap: A1 00 0C 00, 00 00 00 00, 01 00 00 00 → FF FF FF FF. Xor partial: A2 00 06 00 FF 0F → FF 0F 00 00.
- Echo with backpressure: EC 00 08 00 11 22 33 44, with `tx_ready_i` low for 20 cycles, then high → tx 11 22 33 44 in order. A 5th payload byte with `FIFO_DEPTH`=4 full → `err_o` pulse and the byte is dropped.
- Invalid opcode: 55 00 06 00 AA BB, then A0 00 04 00 → one `err_o` at LEN_H, nothing transmitted for the first packet, then 00 00 00 00 for the second.
- Reset: assert `rst_ni` low after 2 operand bytes of an add → all outputs at reset values. A subsequent full packet computes correctly.
- Timeout (macro on, `TIMEOUT_CYCLES`=100): send A0 00 then idle 100 cycles → `err_o` pulse and `busy_o`=0. Macro off → `busy_o` stays 1.
